lsm_reg_sequencer: RTL and testbench

// Register-list sequencer for ARM LDM/STM, one transfer per step. Sits downstream of lsm_manager.
// On START from control unit (driven when LSM_DETECT fires), decodes IR (P,U,W,L,Rn,list).

---
 rtl/lsm_reg_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_lsm_reg_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsm_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lsm_reg_sequencer
// Description : Register-list sequencer for ARM LDM/STM. On start it decodes
//               the instruction (P,U,W,L,Rn,list) and then presents one
//               register number plus word address per transfer, lowest
//               register at lowest address, advancing on each memory ack.
//               It finishes with a one-cycle done pulse carrying the base
//               write-back value.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-high reset
//               start      - begin a sequence (sampled only in IDLE)
//               ir         - instruction: [24]P [23]U [21]W [20]L
//                            [19:16]Rn [15:0]list
//               base_addr  - current value of Rn, sampled with start
//               next       - current transfer completed, advance
//               busy       - high in XFER and FIN
//               xfer_valid - reg_num/addr describe a pending transfer
//               reg_num    - register for the current transfer
//               addr       - word address for the current transfer
//               load       - latched L bit (1 = LDM, 0 = STM)
//               rn         - latched base register number
//               reg_count  - number of registers in the latched list
//               done       - one-cycle end-of-sequence pulse
//               wb_en      - with done: write wb_addr back to rn
//               wb_addr    - final base value
// Revision    : 1.0 - initial release
// ============================================================================
module lsm_reg_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       ir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              next,
  output logic              busy,
  output logic              xfer_valid,
  output logic [3:0]        reg_num,
  output logic [ADDR_W-1:0] addr,
  output logic              load,
  output logic [3:0]        rn,
  output logic [4:0]        reg_count,
  output logic              done,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_xfer = 2'd1;
  localparam logic [1:0] c_st_fin  = 2'd2;

  localparam logic [ADDR_W-1:0] c_stride = ADDR_W'(WORD_BYTES);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;

  logic [15:0]       r_list;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_wb_addr;
  logic              r_load;
  logic              r_w;
  logic [3:0]        r_rn;
  logic [4:0]        r_count;

  logic [4:0]        w_count;
  logic [ADDR_W-1:0] w_span;
  logic [ADDR_W-1:0] w_start_addr;
  logic [ADDR_W-1:0] w_wb_addr;
  logic [3:0]        w_lowest;
  logic [15:0]       w_list_rest;
  logic              w_accept;

  // Condition codes, the LDM/STM opcode field and the S bit are decoded
  // upstream; this block only needs P,U,W,L,Rn and the list.
  logic w_unused_ir;
  assign w_unused_ir = &{1'b0, ir[31:25], ir[22]};

  // --------------------------------------------------------------------------
  // Decode of the incoming instruction (used only at the start edge)
  // --------------------------------------------------------------------------
  always_comb begin
    w_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_count = w_count + {4'd0, ir[i]};
    end
  end

  assign w_span = c_stride * ADDR_W'(w_count);

  // Start address by addressing mode {P,U}; the block always walks upward,
  // so the decrementing modes start at the bottom of the span.
  always_comb begin
    w_start_addr = base_addr;
    case ({ir[24], ir[23]})
      2'b01:   w_start_addr = base_addr;                      // IA
      2'b11:   w_start_addr = base_addr + c_stride;           // IB
      2'b00:   w_start_addr = base_addr - w_span + c_stride;  // DA
      default: w_start_addr = base_addr - w_span;             // DB
    endcase
  end

  assign w_wb_addr = ir[23] ? (base_addr + w_span) : (base_addr - w_span);

  // --------------------------------------------------------------------------
  // Remaining-list handling
  // --------------------------------------------------------------------------
  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    w_lowest = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_list[i]) begin
        w_lowest = 4'(i);
      end
    end
  end

  // x & (x-1) clears exactly the lowest set bit.
  assign w_list_rest = r_list & (r_list - 16'd1);
  assign w_accept    = (r_state == c_st_xfer) && next;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_next_state = (w_count != 5'd0) ? c_st_xfer : c_st_fin;
        end
      end
      c_st_xfer: begin
        if (next && (w_list_rest == 16'd0)) begin
          w_next_state = c_st_fin;
        end
      end
      c_st_fin: begin
        w_next_state = c_st_idle;
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy       = 1'b0;
    xfer_valid = 1'b0;
    done       = 1'b0;
    wb_en      = 1'b0;
    case (r_state)
      c_st_xfer: begin
        busy       = 1'b1;
        xfer_valid = 1'b1;
      end
      c_st_fin: begin
        busy  = 1'b1;
        done  = 1'b1;
        wb_en = r_w;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign reg_num   = w_lowest;
  assign addr      = r_addr;
  assign load      = r_load;
  assign rn        = r_rn;
  assign reg_count = r_count;
  assign wb_addr   = r_wb_addr;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_list    <= 16'd0;
      r_addr    <= '0;
      r_wb_addr <= '0;
      r_load    <= 1'b0;
      r_w       <= 1'b0;
      r_rn      <= 4'd0;
      r_count   <= 5'd0;
    end else if ((r_state == c_st_idle) && start) begin
      r_list    <= ir[15:0];
      r_addr    <= w_start_addr;
      r_wb_addr <= w_wb_addr;
      r_load    <= ir[20];
      r_w       <= ir[21];
      r_rn      <= ir[19:16];
      r_count   <= w_count;
    end else if (w_accept) begin
      r_list <= w_list_rest;
      r_addr <= r_addr + c_stride;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsm_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsm_reg_sequencer
// Description : Scoreboard bench for lsm_reg_sequencer. Directed sequences
//               push hand-computed transfers and completion records into a
//               queue; a monitor pops and compares on each accepted transfer
//               and on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsm_reg_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] ir;
  logic [31:0] base_addr;
  logic        next;
  logic        busy;
  logic        xfer_valid;
  logic [3:0]  reg_num;
  logic [31:0] addr;
  logic        load;
  logic [3:0]  rn;
  logic [4:0]  reg_count;
  logic        done;
  logic        wb_en;
  logic [31:0] wb_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_done;
    logic [3:0]  reg_n;
    logic [31:0] addr;
    logic        wb_en;
    logic [31:0] wb_addr;
    logic        load;
    logic [3:0]  rn;
    logic [4:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  lsm_reg_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ir         (ir),
    .base_addr  (base_addr),
    .next       (next),
    .busy       (busy),
    .xfer_valid (xfer_valid),
    .reg_num    (reg_num),
    .addr       (addr),
    .load       (load),
    .rn         (rn),
    .reg_count  (reg_count),
    .done       (done),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_x(input logic [3:0] r, input logic [31:0] a);
    exp_t e;
    e = '{is_done: 1'b0, reg_n: r, addr: a, wb_en: 1'b0, wb_addr: 32'd0,
          load: 1'b0, rn: 4'd0, cnt: 5'd0};
    exp_q.push_back(e);
  endtask

  task automatic exp_d(input logic en, input logic [31:0] wa, input logic ld,
                       input logic [3:0] r, input logic [4:0] c);
    exp_t e;
    e = '{is_done: 1'b1, reg_n: 4'd0, addr: 32'd0, wb_en: en, wb_addr: wa,
          load: ld, rn: r, cnt: c};
    exp_q.push_back(e);
  endtask

  // Monitor: compares on every accepted transfer and every done pulse.
  always @(negedge clk) begin
    if (!reset && ((xfer_valid && next) || done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {62'd0, xfer_valid, done}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (xfer_valid) begin
          chk("kind_xfer", 64'(e.is_done), 64'd0);
          chk("reg_num", 64'(reg_num), 64'(e.reg_n));
          chk("addr", 64'(addr), 64'(e.addr));
          chk("busy_xfer", 64'(busy), 64'd1);
        end else begin
          chk("kind_done", 64'(e.is_done), 64'd1);
          chk("wb_en", 64'(wb_en), 64'(e.wb_en));
          chk("wb_addr", 64'(wb_addr), 64'(e.wb_addr));
          chk("load", 64'(load), 64'(e.load));
          chk("rn", 64'(rn), 64'(e.rn));
          chk("reg_count", 64'(reg_count), 64'(e.cnt));
          chk("busy_done", 64'(busy), 64'd1);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_outputs"},
        {busy, xfer_valid, reg_num, addr, load, rn, reg_count, done, wb_en},
        64'd0);
    chk({tag, "_wb_addr"}, 64'(wb_addr), 64'd0);
  endtask

  // Runs one sequence: stall = cycles NEXT is held low on the first transfer,
  // midstart = cycle index at which a stray START is pulsed (0 = none),
  // exp_lat = expected number of cycles from START deassert to DONE.
  task automatic run_seq(input logic [31:0] i_ir, input logic [31:0] b,
                         input int stall, input int midstart, input int exp_lat,
                         input string name);
    int          cyc;
    bit          seen;
    logic [3:0]  hold_reg;
    logic [31:0] hold_addr;
    cyc  = 0;
    seen = 1'b0;
    hold_reg  = 4'd0;
    hold_addr = 32'd0;
    @(posedge clk); #1;
    ir        = i_ir;
    base_addr = b;
    start     = 1'b1;
    next      = (stall == 0);
    @(posedge clk); #1;
    start     = 1'b0;
    ir        = 32'hFFFF_FFFF;
    base_addr = 32'hDEAD_BEEF;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else if (cyc <= stall) begin
        chk({name, "_stall_valid"}, 64'(xfer_valid), 64'd1);
        if (cyc == 1) begin
          hold_reg  = reg_num;
          hold_addr = addr;
        end else begin
          chk({name, "_stall_reg"}, 64'(reg_num), 64'(hold_reg));
          chk({name, "_stall_addr"}, 64'(addr), 64'(hold_addr));
        end
      end
      if (!seen) begin
        @(posedge clk); #1;
        if (cyc == stall) next = 1'b1;
        start = (cyc == midstart);
      end
    end
    start = 1'b0;
    chk({name, "_done_latency"}, 64'(cyc), 64'(exp_lat));
    @(posedge clk); #1;
    chk({name, "_idle_after_done"}, {62'd0, busy, done}, 64'd0);
    chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    ir        = 32'd0;
    base_addr = 32'd0;
    next      = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: LDMIA sp!,{r0-r3}
    exp_x(4'd0, 32'h1000); exp_x(4'd1, 32'h1004);
    exp_x(4'd2, 32'h1008); exp_x(4'd3, 32'h100C);
    exp_d(1'b1, 32'h1010, 1'b1, 4'd13, 5'd4);
    run_seq(32'hE8BD000F, 32'h1000, 0, 0, 5, "ldmia");

    // 2: STMDB sp!,{r4,lr}
    exp_x(4'd4, 32'h1FF8); exp_x(4'd14, 32'h1FFC);
    exp_d(1'b1, 32'h1FF8, 1'b0, 4'd13, 5'd2);
    run_seq(32'hE92D4010, 32'h2000, 0, 0, 3, "stmdb");

    // 3: LDMIB r0,{r1,r5} with a 3-cycle stall on the first transfer
    exp_x(4'd1, 32'h104); exp_x(4'd5, 32'h108);
    exp_d(1'b0, 32'h108, 1'b1, 4'd0, 5'd2);
    run_seq(32'hE9900022, 32'h100, 3, 0, 6, "ldmib_stall");

    // 4: STMDA r2,{r0}
    exp_x(4'd0, 32'h40);
    exp_d(1'b0, 32'h3C, 1'b0, 4'd2, 5'd1);
    run_seq(32'hE8020001, 32'h40, 0, 0, 2, "stmda");

    // 4b: empty list -> straight to done, write-back equals base
    exp_d(1'b1, 32'h1234, 1'b1, 4'd13, 5'd0);
    run_seq(32'hE8BD0000, 32'h1234, 0, 0, 1, "empty");

    // 5: address wrap, with a stray START mid-sequence
    exp_x(4'd0, 32'hFFFF_FFF8); exp_x(4'd1, 32'hFFFF_FFFC);
    exp_x(4'd2, 32'h0000_0000); exp_x(4'd3, 32'h0000_0004);
    exp_d(1'b1, 32'h8, 1'b1, 4'd13, 5'd4);
    run_seq(32'hE8BD000F, 32'hFFFF_FFF8, 0, 2, 5, "wrap_midstart");

    // 6: reset asserted while the second transfer is pending
    exp_x(4'd0, 32'h1000);
    @(posedge clk); #1;
    ir        = 32'hE8BD000F;
    base_addr = 32'h1000;
    start     = 1'b1;
    next      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    next = 1'b0;
    @(negedge clk);
    chk("rst_second_valid", 64'(xfer_valid), 64'd1);
    chk("rst_second_reg", 64'(reg_num), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    chk("rst_queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    exp_x(4'd0, 32'h1000); exp_x(4'd1, 32'h1004);
    exp_x(4'd2, 32'h1008); exp_x(4'd3, 32'h100C);
    exp_d(1'b1, 32'h1010, 1'b1, 4'd13, 5'd4);
    run_seq(32'hE8BD000F, 32'h1000, 0, 0, 5, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
